// File: rtl/buffer_pkg.sv
// Shared constants and pointer helper for the pipeline-stage buffer.
package buffer_pkg;
  localparam int BUF_DEFAULT_WIDTH = 32;
  localparam int BUF_DEFAULT_DEPTH = 2;

  // Wrap by explicit compare so non-power-of-two depths work.
  function automatic int unsigned ptr_next(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 1) ? 0 : ptr + 1;
  endfunction
endpackage

// File: rtl/buffer_mem.sv
// Storage array: one synchronous write port, one asynchronous read port.
module buffer_mem
  import buffer_pkg::*;
#(
  parameter int WIDTH = BUF_DEFAULT_WIDTH,
  parameter int DEPTH = BUF_DEFAULT_DEPTH,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic             ref_clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);
  logic [WIDTH-1:0] mem [DEPTH];

  // Contents are deliberately left uninitialised; reset only clears control.
  always_ff @(posedge ref_clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];
endmodule

// File: rtl/pipe_skid_buffer.sv
// FIFO stage buffer with valid/ready on both sides and synchronous flush.
module pipe_skid_buffer
  import buffer_pkg::*;
#(
  parameter int WIDTH = BUF_DEFAULT_WIDTH,
  parameter int DEPTH = BUF_DEFAULT_DEPTH
) (
  input  logic                       ref_clk,
  input  logic                       reset,
  input  logic                       flush,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [WIDTH-1:0]           in_data,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [WIDTH-1:0]           out_data,
  output logic [$clog2(DEPTH+1)-1:0] count
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH + 1);

  logic [PW-1:0]    rdPtr, wrPtr;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] headData;
  logic             push, pop, squash;

  // Handshake flags come only from registered count: no out_ready -> in_ready path.
  assign in_ready  = (cnt != CW'(DEPTH));
  assign out_valid = (cnt != '0);
  assign out_data  = out_valid ? headData : '0;
  assign count     = cnt;

  assign push   = in_valid && in_ready;
  assign pop    = out_valid && out_ready;
  assign squash = reset || flush;

  buffer_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(PW)) uMem (
    .ref_clk (ref_clk),
    .we      (push && !squash),
    .waddr   (wrPtr),
    .wdata   (in_data),
    .raddr   (rdPtr),
    .rdata   (headData)
  );

  always_ff @(posedge ref_clk) begin
    if (squash) begin
      rdPtr <= '0;
      wrPtr <= '0;
      cnt   <= '0;
    end else begin
      if (push) wrPtr <= PW'(ptr_next(32'(wrPtr), DEPTH));
      if (pop)  rdPtr <= PW'(ptr_next(32'(rdPtr), DEPTH));
      case ({push, pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end
endmodule

// File: tb/tb_pipe_skid_buffer.sv
// Drives DEPTH=2 and DEPTH=3 buffers in lockstep against queue models.
module tb_pipe_skid_buffer;
  logic        ref_clk = 0;
  logic        reset = 0, flush = 0, inValid = 0, outReady = 0;
  logic [31:0] inData = '0;

  logic        inReady2, outValid2, inReady3, outValid3;
  logic [31:0] outData2, outData3;
  logic [1:0]  count2, count3;

  logic [31:0] q2[$], q3[$];
  int  vectors = 0, miscompares = 0;
  bit  chk = 0;

  always #5 ref_clk = ~ref_clk;

  pipe_skid_buffer #(.WIDTH(32), .DEPTH(2)) dut2 (
    .ref_clk(ref_clk), .reset(reset), .flush(flush), .in_valid(inValid),
    .in_ready(inReady2), .in_data(inData), .out_valid(outValid2),
    .out_ready(outReady), .out_data(outData2), .count(count2));

  pipe_skid_buffer #(.WIDTH(32), .DEPTH(3)) dut3 (
    .ref_clk(ref_clk), .reset(reset), .flush(flush), .in_valid(inValid),
    .in_ready(inReady3), .in_data(inData), .out_valid(outValid3),
    .out_ready(outReady), .out_data(outData3), .count(count3));

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s got %h want %h at %0t", nm, act, exp, $time);
    end
  endtask

  // Queue model: reset/flush empty it; pop and push judged on pre-edge occupancy.
  task automatic modelStep(inout logic [31:0] q[$], input int depth);
    bit doPop, doPush;
    if (reset || flush) begin
      q.delete();
    end else begin
      doPop  = outReady && (q.size() != 0);
      doPush = inValid && (q.size() != depth);
      if (doPop)  void'(q.pop_front());
      if (doPush) q.push_back(inData);
    end
  endtask

  always @(negedge ref_clk) begin
    if (chk) begin
      check("d2.count",    32'(count2),    32'(q2.size()));
      check("d2.outValid", 32'(outValid2), 32'(q2.size() != 0));
      check("d2.inReady",  32'(inReady2),  32'(q2.size() != 2));
      check("d2.outData",  outData2,       q2.size() != 0 ? q2[0] : 32'h0);
      check("d3.count",    32'(count3),    32'(q3.size()));
      check("d3.outValid", 32'(outValid3), 32'(q3.size() != 0));
      check("d3.inReady",  32'(inReady3),  32'(q3.size() != 3));
      check("d3.outData",  outData3,       q3.size() != 0 ? q3[0] : 32'h0);
    end
  end

  task automatic step(input logic iv, input logic [31:0] d, input logic ordy,
                      input logic fl, input logic rst);
    inValid = iv; inData = d; outReady = ordy; flush = fl; reset = rst;
    @(posedge ref_clk);
    modelStep(q2, 2);
    modelStep(q3, 3);
    #1;
  endtask

  task automatic rst();
    step(0, 0, 0, 0, 1);
  endtask

  initial begin
    // Test 1: basic fill / refuse / drain on DEPTH=2
    rst();
    chk = 1;
    check("t1.rstCount",  32'(count2), 32'd0);
    check("t1.rstReady",  32'(inReady2), 32'd1);
    check("t1.rstValid",  32'(outValid2), 32'd0);
    check("t1.rstData",   outData2, 32'h0);
    step(1, 32'h7FF, 0, 0, 0);
    check("t1.valid",     32'(outValid2), 32'd1);
    check("t1.data",      outData2, 32'h7FF);
    check("t1.count1",    32'(count2), 32'd1);
    check("t1.ready1",    32'(inReady2), 32'd1);
    step(1, 32'h1, 0, 0, 0);
    check("t1.count2",    32'(count2), 32'd2);
    check("t1.ready0",    32'(inReady2), 32'd0);
    step(1, 32'h2, 0, 0, 0);
    check("t1.refused",   32'(count2), 32'd2);
    check("t1.head",      outData2, 32'h7FF);
    step(0, 0, 1, 0, 0);
    check("t1.pop1",      outData2, 32'h1);
    step(0, 0, 1, 0, 0);
    check("t1.empty",     32'(count2), 32'd0);
    check("t1.emptyData", outData2, 32'h0);

    // Test 2: steady stream, pointers wrap on DEPTH=3
    rst();
    for (int i = 0; i < 10; i++) begin
      step(1, 32'(i), 1, 0, 0);
      check("t2.count", 32'(count3), 32'd1);
      check("t2.data",  outData3, 32'(i));
    end
    step(0, 0, 1, 0, 0);

    // Test 3: full plus simultaneous pop refuses the push
    rst();
    step(1, 32'hA, 0, 0, 0);
    step(1, 32'hB, 0, 0, 0);
    step(1, 32'hC, 1, 0, 0);
    check("t3.count", 32'(count2), 32'd1);
    check("t3.data",  outData2, 32'hB);

    // Test 4: flush discards stored entries and the concurrent push
    rst();
    step(1, 32'h11, 0, 0, 0);
    step(1, 32'h22, 0, 0, 0);
    step(1, 32'h33, 0, 1, 0);
    check("t4.count", 32'(count2), 32'd0);
    check("t4.valid", 32'(outValid2), 32'd0);
    check("t4.data",  outData2, 32'h0);
    check("t4.ready", 32'(inReady2), 32'd1);
    step(1, 32'h44, 0, 0, 0);
    check("t4.first", outData2, 32'h44);

    // Test 5: reset mid-operation with push and pop active
    rst();
    step(1, 32'h55, 0, 0, 0);
    step(1, 32'h56, 0, 0, 0);
    step(1, 32'h57, 1, 0, 1);
    check("t5.count", 32'(count2), 32'd0);
    check("t5.valid", 32'(outValid2), 32'd0);
    check("t5.data",  outData2, 32'h0);
    check("t5.ready", 32'(inReady2), 32'd1);
    step(1, 32'h66, 0, 0, 0);
    step(1, 32'h77, 0, 0, 0);
    check("t5.refill0", outData2, 32'h66);
    step(0, 0, 1, 0, 0);
    check("t5.refill1", outData2, 32'h77);

    // Test 6: stall holds the head stable
    rst();
    step(1, 32'hDEADBEEF, 0, 0, 0);
    for (int k = 0; k < 5; k++) begin
      step(1, 32'h5, 0, 0, 0);
      check("t6.hold",  outData2, 32'hDEADBEEF);
      check("t6.count", 32'(count2), 32'd2);
    end

    // Random traffic with occasional flush and reset
    rst();
    for (int n = 0; n < 400; n++) begin
      step(1'($urandom_range(0, 3) != 0), $urandom, 1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 15) == 0), 1'($urandom_range(0, 63) == 0));
    end

    @(negedge ref_clk);
    chk = 0;
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
